// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write port of the
// program loader, bundled so the loader and its environment share one port.
//
// Signals
//   in_valid  : byte-stream data valid (from the byte source)
//   in_data   : byte-stream payload, 8 bits
//   in_ready  : loader can accept a byte this cycle
//   mem_we    : instruction-memory write strobe
//   mem_addr  : instruction-memory write address, ADDR_W bits
//   mem_wd    : 16-bit instruction word to write
//
// Handshake: a byte transfers on a rising clock edge exactly when in_valid and
// in_ready are both 1 in that cycle. in_data is ignored in every other cycle.
// in_ready depends only on loader state, never on in_valid.
//
// Modports
//   slave  : the loader (consumes bytes, drives the memory write port)
//   master : the environment (byte source and memory)

interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wd;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wd
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wd
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a program over a byte stream and writes it into the
// instruction memory while holding the processor in reset.
//
// Stream: 2-byte word count N (high byte first), then N 16-bit words (high
// byte first). Each word is written one cycle after its low byte arrives.
// N = 0 or N > 2^ADDR_W aborts the load, as does a gap of TIMEOUT cycles
// without a byte while a load is in progress.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : one-cycle load request (honoured in IDLE/DONE/ERR only)
//   bus          : byte stream in, memory write port out (prog_loader_if)
//   cpu_reset    : processor reset, released only in DONE
//   busy         : load in progress (LEN_HI .. WRITE)
//   done         : last load completed successfully
//   err          : last load aborted
//   words_loaded : words written in the current or last load
//   dbg_state    : current FSM state encoding

module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DAT_HI = 3'd3,
    DAT_LO = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [16:0]     MAX_N   = 17'(2 ** ADDR_W);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wd_q, mem_wd_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic        rx_state;
  logic        hs;
  logic [15:0] n_full;
  logic [16:0] wl_next_ext;

  assign rx_state = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DAT_HI) || (state_q == DAT_LO);
  assign hs       = bus.in_valid && rx_state;
  assign n_full   = {len_q[15:8], bus.in_data};
  // Words written including the one being written this cycle.
  assign wl_next_ext = 17'(wl_q) + 17'd1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    wl_d       = wl_q;
    to_d       = to_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          wl_d    = '0;
          to_d    = '0;
        end
      end
      LEN_HI: begin
        if (hs) begin
          len_d[15:8] = bus.in_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (hs) begin
          len_d[7:0] = bus.in_data;
          if ((n_full == 16'd0) || ({1'b0, n_full} > MAX_N)) begin
            state_d = ERR;
          end else begin
            // The write address is words_loaded itself, already zero here.
            state_d = DAT_HI;
          end
        end
      end
      DAT_HI: begin
        if (hs) begin
          hi_d    = bus.in_data;
          state_d = DAT_LO;
        end
      end
      DAT_LO: begin
        if (hs) begin
          // Present the word on the memory port as WRITE is entered; the
          // registers then hold it until the next word's WRITE.
          mem_addr_d = wl_q[ADDR_W-1:0];
          mem_wd_d   = {hi_q, bus.in_data};
          state_d    = WRITE;
        end
      end
      WRITE: begin
        wl_d = wl_q + 1'b1;
        if (wl_next_ext == {1'b0, len_q}) begin
          state_d = DONE;
        end else begin
          state_d = DAT_HI;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inactivity watchdog for the four byte-receiving states.
    if (rx_state) begin
      if (hs) begin
        to_d = '0;
      end else begin
        to_d = to_q + TO_W'(1);
        if (to_q == TO_LAST) begin
          state_d = ERR;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      wl_q       <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      wl_q       <= wl_d;
      to_q       <= to_d;
    end
  end

  assign bus.in_ready  = rx_state;
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wd    = mem_wd_q;
  assign busy          = rx_state || (state_q == WRITE);
  assign done          = (state_q == DONE);
  assign err           = (state_q == ERR);
  assign cpu_reset     = (state_q != DONE);
  assign words_loaded  = wl_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
// A reference model turns each byte stream into the list of memory writes
// and the final outcome; a monitor checks every mem_we pulse against it.

module tb_prog_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 1000;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int W       = ADDR_W + 16;

  logic            clk;
  logic            reset;
  logic            start;
  logic            cpu_reset;
  logic            busy;
  logic            done;
  logic            err;
  logic [ADDR_W:0] words_loaded;
  logic [2:0]      dbg_state;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus_if.slave),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus_if.mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(bus_if.mem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus_if.mem_addr), 32'(e[W-1:16]));
        check("wr_data", 32'(bus_if.mem_wd), 32'(e[15:0]));
      end
    end
  end

  // ---------------- reference model ----------------
  // Decides the outcome of a stream and queues the writes it must produce.
  task automatic model_stream(input logic [7:0] b[$], output bit ok,
                              output int n, output int nbytes);
    int cnt;
    cnt = int'({b[0], b[1]});
    ok  = (cnt != 0) && (cnt <= DEPTH);
    if (ok) begin
      n      = cnt;
      nbytes = 2 + 2 * cnt;
      for (int i = 0; i < cnt; i++)
        exp_q.push_back({ADDR_W'(i), b[2 + 2 * i], b[3 + 2 * i]});
    end else begin
      n      = 0;
      nbytes = 2;
    end
  endtask

  task automatic make_stream(input int cnt, input int payload_words, output logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'(cnt);
    b = {};
    b.push_back(c[15:8]);
    b.push_back(c[7:0]);
    for (int i = 0; i < 2 * payload_words; i++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- drivers ----------------
  // Called and returns at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: in_valid held 1; mode 1: toggling with stray start pulses;
  // mode 2: random in_valid. Returns at a falling edge.
  task automatic feed(input logic [7:0] b[$], input int nbytes, input int mode);
    int  idx;
    int  guard;
    bit  v;
    bit  hs;
    bit  phase;
    idx   = 0;
    guard = 0;
    phase = 1'b1;
    while (idx < nbytes && guard < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = phase;
        default: v = 1'($urandom_range(0, 1));
      endcase
      phase = ~phase;
      if (mode == 1) start = ($urandom_range(0, 2) == 0);
      bus_if.in_valid = v;
      bus_if.in_data  = v ? b[idx] : 8'($urandom_range(0, 255));
      hs = v && bus_if.in_ready;
      @(posedge clk);
      if (hs) idx++;
      guard++;
      @(negedge clk);
    end
    start           = 1'b0;
    bus_if.in_valid = 1'b0;
    if (idx != nbytes) check("feed_budget", 32'(idx), 32'(nbytes));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus_if.in_ready), 32'd0);
    check({tag, "_mem_we"},    32'(bus_if.mem_we),   32'd0);
    check({tag, "_mem_addr"},  32'(bus_if.mem_addr), 32'd0);
    check({tag, "_mem_wd"},    32'(bus_if.mem_wd),   32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset),       32'd1);
    check({tag, "_busy"},      32'(busy),            32'd0);
    check({tag, "_done"},      32'(done),            32'd0);
    check({tag, "_err"},       32'(err),             32'd0);
    check({tag, "_wl"},        32'(words_loaded),    32'd0);
  endtask

  // Full load: model, start, feed, wait for the end, check outcome.
  task automatic run_load(input logic [7:0] b[$], input int mode);
    bit ok;
    int n;
    int nbytes;
    int waitc;
    model_stream(b, ok, n, nbytes);
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_clr",  32'({done, err, cpu_reset}), 32'b001);
    check("start_wl",   32'(words_loaded), 32'd0);
    feed(b, nbytes, mode);
    waitc = 0;
    while (!(done || err) && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!(done || err)) check("end_wait", 32'(waitc), 32'd0);
    check("done",      32'(done),      32'(ok));
    check("err",       32'(err),       32'(!ok));
    check("cpu_reset", 32'(cpu_reset), 32'(!ok));
    check("busy_end",  32'(busy),      32'd0);
    check("ready_end", 32'(bus_if.in_ready), 32'd0);
    check("wl_end",    32'(words_loaded), 32'(n));
    check("wr_left",   32'(exp_q.size()), 32'd0);
    exp_q = {};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] b[$];
    logic [15:0] last_word;
    reset           = 1'b1;
    start           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed two-word load.
    b = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_load(b, 0);

    // Zero and oversize word counts.
    b = {8'h00, 8'h00};
    run_load(b, 0);
    b = {8'h04, 8'h01};
    run_load(b, 0);

    // Full-capacity load: last write lands on the top address and holds.
    make_stream(DEPTH, DEPTH, b);
    last_word = {b[b.size() - 2], b[b.size() - 1]};
    run_load(b, 0);
    check("full_last_addr", 32'(bus_if.mem_addr), 32'(DEPTH - 1));
    check("full_last_wd",   32'(bus_if.mem_wd),   32'(last_word));

    // Inactivity abort after a partial word, then a clean reload.
    b = {8'h00, 8'h01, 8'h12};
    pulse_start();
    feed(b, 3, 0);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("to_early_err",  32'(err),  32'd0);
    check("to_early_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("to_err",       32'(err),       32'd1);
    check("to_cpu_reset", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    make_stream(2, 2, b);
    run_load(b, 0);

    // Toggling valid with stray start pulses: same writes as back-to-back.
    make_stream(3, 3, b);
    run_load(b, 1);

    // Reset between the two bytes of word 2.
    b = {8'h00, 8'h03, 8'h12, 8'h34, 8'h56};
    exp_q.push_back({ADDR_W'(0), 16'h1234});
    pulse_start();
    feed(b, 5, 0);
    check("mid_state_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h78;
    repeat (5) @(negedge clk);
    check("post_rst_ready", 32'(bus_if.in_ready), 32'd0);
    check("post_rst_busy",  32'(busy),            32'd0);
    check("post_rst_cpu",   32'(cpu_reset),       32'd1);
    check("post_rst_wr",    32'(exp_q.size()),    32'd0);
    bus_if.in_valid = 1'b0;
    exp_q = {};

    // Random loads, including invalid counts.
    for (int t = 0; t < 10; t++) begin
      int cnt;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       cnt = 0;
        1:       cnt = DEPTH + $urandom_range(1, 60000);
        default: cnt = $urandom_range(1, 12);
      endcase
      make_stream(cnt, (cnt >= 1 && cnt <= DEPTH) ? cnt : 0, b);
      run_load(b, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory address width (capacity 2^ADDR_W words).
REQ-002 Parameter: TIMEOUT, default 1000, maximum idle cycles between accepted bytes while a load is in progress.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: start  input  1  one-cycle request to begin a load.
REQ-006 Port: in_valid  input  1  byte-stream data valid.
REQ-007 Port: in_data  input  8  byte-stream payload.
REQ-008 Port: in_ready  output  1  loader can accept a byte this cycle.
REQ-009 Port: mem_we  output  1  instruction-memory write strobe.
REQ-010 Port: mem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 Port: mem_wd  output  16  instruction word to write.
REQ-012 Port: cpu_reset  output  1  holds the processor datapath and control unit in reset.
REQ-013 Port: busy  output  1  load in progress.
REQ-014 Port: done  output  1  last load completed successfully.
REQ-015 Port: err  output  1  last load aborted.
REQ-016 Port: words_loaded  output  ADDR_W+1  count of words written in the current or last load.

Function
REQ-017 The byte is accepted on a cycle only when in_valid=1 and in_ready=1 (handshake); in_data is ignored otherwise.
REQ-018 Stream format: 2-byte word count N (high byte first), then N instruction words of 2 bytes each (high byte first).
REQ-019 States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, DONE, ERR.
REQ-020 IDLE/DONE/ERR: start=1 moves to LEN_HI next cycle and clears done, err, words_loaded; start is ignored in all other states.
REQ-021 LEN_HI: on handshake latch N[15:8], go to LEN_LO.
REQ-022 LEN_LO: on handshake latch N[7:0]; if N=0 or N>2^ADDR_W go to ERR, else clear address to 0 and go to DAT_HI.
REQ-023 DAT_HI: on handshake latch word[15:8], go to DAT_LO; DAT_LO: on handshake latch word[7:0], go to WRITE.
REQ-024 WRITE: in_ready=0; mem_we=1 for exactly this one cycle with mem_addr=current address and mem_wd={hi,lo}; address and words_loaded increment by 1; go to DONE if words_loaded reaches N, else DAT_HI.
REQ-025 in_ready=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO; mem_we=0 in every state except WRITE.
REQ-026 Maximum throughput: one word per 3 cycles (two byte handshakes plus WRITE).
REQ-027 Address wraps never occur: N=2^ADDR_W writes addresses 0..2^ADDR_W-1, then DONE without further increment of mem_addr beyond the final write.
REQ-028 Timeout counter clears on every handshake and on entry to LEN_HI; it increments each cycle in LEN_HI/LEN_LO/DAT_HI/DAT_LO without a handshake; reaching TIMEOUT forces ERR next cycle.
REQ-029 busy=1 in LEN_HI through WRITE; done=1 only in DONE; err=1 only in ERR.
REQ-030 cpu_reset=0 only in DONE; 1 in all other states, so the processor runs only after a complete load and is re-held as soon as a reload starts.
REQ-031 mem_addr and mem_wd hold their last values outside WRITE.

Reset
REQ-032 reset=1 forces IDLE asynchronously: in_ready=0, mem_we=0, mem_addr=0, mem_wd=0, cpu_reset=1, busy=0, done=0, err=0, words_loaded=0, timeout counter=0.
REQ-033 reset asserted mid-load abandons the load with no further mem_we pulse; a fresh start is required after release.

Verification
REQ-034 Reset then start, bytes 00 02 12 34 AB CD with in_valid held 1 -> mem_we pulses at addr 0 data 0x1234 and addr 1 data 0xABCD, done=1, cpu_reset=0, words_loaded=2.
REQ-035 Bytes 00 00 -> ERR: err=1, cpu_reset=1, no mem_we pulse.
REQ-036 Bytes 04 01 (N=1025, ADDR_W=10) -> ERR, no write; N=1024 stream -> last write at addr 1023, DONE.
REQ-037 After 00 01 12, in_valid held 0 for TIMEOUT cycles -> ERR, no write; then start with valid stream -> DONE, err cleared.
REQ-038 in_valid toggling 1/0 every cycle during a 3-word load -> same memory contents as back-to-back; start pulses during the load ignored.
REQ-039 reset pulsed between DAT_HI and DAT_LO of word 2 -> all outputs at REQ-032 values immediately, no write for word 2, cpu_reset=1.
